pack_fifo: RTL and testbench

- Transmit-side counterpart of the 128-bit block extractor.
- Accepts one 128-bit block (for example an AES ciphertext block) through a valid/ready handshake.
- Serializes the block into 16 bytes and pushes them into the downstream byte-wide data FIFO, most-significant byte first, honouring the FIFO full flag.
- Pulses done once the last byte of the block has been written.

---
 rtl/pack_fifo_if.sv | 29 ++
 rtl/pack_fifo.sv | 91 +++++++++
 tb/tb_pack_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pack_fifo_if.sv
// Block-to-byte packer bus: block handshake in, byte FIFO write port out, status.
// Latency: none (wires only).
// Backpressure: full from the byte FIFO, in_ready towards the block source.
// Ports: in_valid/in/in_ready block handshake; full/push/data FIFO write port;
//        busy/done/byte_cnt status. master = packer side, slave = environment side.
interface pack_fifo_if #(
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
);
  logic                     in_valid;
  logic [8*BLOCK_BYTES-1:0] in;
  logic                     in_ready;
  logic                     full;
  logic                     push;
  logic [7:0]               data;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         byte_cnt;

  modport master (
    input  in_valid, in, full,
    output in_ready, push, data, busy, done, byte_cnt
  );

  modport slave (
    output in_valid, in, full,
    input  in_ready, push, data, busy, done, byte_cnt
  );
endinterface

// File: rtl/pack_fifo.sv
// Serializes one BLOCK_BYTES-wide block into bytes, MSB first, into a byte FIFO.
// Latency: accept at edge N, bytes on edges N+1..N+BLOCK_BYTES, done the cycle after.
// Backpressure: full stalls the byte stream (data held); in_ready low while busy/done.
// Ports: clk, rst (sync, active-high); bus (pack_fifo_if.master) carries the block
//        handshake, the FIFO write port (push/data/full) and busy/done/byte_cnt.
module pack_fifo #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  pack_fifo_if.master bus
);
  localparam int BW    = 8 * BLOCK_BYTES;
  localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    bus.in_ready = 1'b0;
    bus.push     = 1'b0;
    bus.data     = 8'h00;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          shift_d = bus.in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        bus.busy = 1'b1;
        bus.data = shift_q[BW-1 -: 8];
        // A reset edge abandons the block, so the byte in flight on that edge
        // must not be handed to the FIFO either.
        bus.push = !bus.full && !rst;
        if (!bus.full) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BYTE) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // cnt_q already reads BLOCK_BYTES here; clear it on the way back to IDLE.
        bus.done = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.byte_cnt = cnt_q;

endmodule

// File: tb/tb_pack_fifo.sv
module tb_pack_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pack_fifo_if #(.BLOCK_BYTES(16)) bus ();

  pack_fifo #(.BLOCK_BYTES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: the byte stream the FIFO should see, and the number of blocks
  // that should have completed.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         done_n    = 0;
  int         blocks_ok = 0;

  // Inputs only change just after a rising edge, so what is seen at the
  // falling edge is what the FIFO samples at the next rising edge.
  always @(negedge clk) begin
    if (bus.push) got_q.push_back(bus.data);
    if (bus.done) done_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte k of a block in transmission order (byte 0 = most significant).
  function automatic logic [7:0] byte_of(input logic [127:0] b, input int k);
    logic [127:0] t;
    t = b >> (8 * (15 - k));
    return t[7:0];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_push"},  bus.push,     1'b0);
    chk({tag, "_busy"},  bus.busy,     1'b0);
    chk({tag, "_done"},  bus.done,     1'b0);
    chk({tag, "_cnt"},   bus.byte_cnt, 5'd0);
    chk({tag, "_data"},  bus.data,     8'h00);
  endtask

  // Send one block. Called just after a rising edge with the DUT idle.
  // full is either random per cycle, or held for stall_len cycles once
  // stall_at bytes are out. inj_at>=0 pulses in_valid with a foreign block
  // once that many bytes are out.
  task automatic xfer(input logic [127:0] blk, input int stall_at, input int stall_len,
                      input int inj_at, input bit rnd);
    int k;
    int stalls;
    int lat;
    bit injected;
    chk("acc_ready", bus.in_ready, 1'b1);
    bus.in       = blk;
    bus.in_valid = 1'b1;
    bus.full     = 1'b0;
    step();
    bus.in_valid = 1'b0;
    k = 0; stalls = 0; lat = 0; injected = 1'b0;
    while (k < 16 && lat < 200) begin
      if (rnd) bus.full = ($urandom_range(0, 3) == 0);
      else     bus.full = (k == stall_at && stalls < stall_len);
      if (k == inj_at && !injected) begin
        bus.in_valid = 1'b1;
        bus.in       = ~blk;
        injected     = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk("send_busy",  bus.busy,     1'b1);
      chk("send_ready", bus.in_ready, 1'b0);
      chk("send_done",  bus.done,     1'b0);
      chk("send_data",  bus.data,     byte_of(blk, k));
      chk("send_push",  bus.push,     !bus.full);
      chk("send_cnt",   bus.byte_cnt, k[4:0]);
      if (bus.full) stalls++;
      else begin
        exp_q.push_back(byte_of(blk, k));
        k++;
      end
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    bus.full     = 1'b0;
    chk("send_timeout", lat < 200, 1'b1);
    #1;
    chk("done_pulse", bus.done,     1'b1);
    chk("done_cnt",   bus.byte_cnt, 5'd16);
    chk("done_push",  bus.push,     1'b0);
    chk("done_busy",  bus.busy,     1'b0);
    chk("done_ready", bus.in_ready, 1'b0);
    blocks_ok++;
    step();
    chk_idle("post");
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    int c;
    int acc;
    int t_a;
    int t_b;
    int d0;

    bus.in_valid = 1'b1;
    bus.in       = {$urandom, $urandom, $urandom, $urandom};
    bus.full     = 1'b0;

    // Reset with a pending block: nothing is captured.
    rst = 1'b1;
    repeat (3) begin
      step();
      chk_idle("rst");
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_idle("rst_rel");

    // Plain block, no backpressure.
    xfer(128'h000102030405060708090A0B0C0D0E0F, -1, 0, -1, 1'b0);

    // Same block, FIFO full for 5 cycles after the 4th byte.
    xfer(128'h000102030405060708090A0B0C0D0E0F, 4, 5, -1, 1'b0);

    // Stall on the final byte.
    xfer(128'h0F0E0D0C0B0A09080706050403020100, 15, 3, -1, 1'b0);

    // Back-to-back with in_valid held high: second accept 18 edges later.
    a = 128'hFFEEDDCCBBAA99887766554433221100;
    b = 128'h112233445566778899AABBCCDDEEFF00;
    bus.in = a; bus.in_valid = 1'b1; bus.full = 1'b0;
    c = 0; acc = 0; t_a = 0; t_b = 0;
    d0 = done_n;
    while (acc < 2 && c < 100) begin
      #1;
      if (bus.in_ready) begin
        if (acc == 0) t_a = c; else t_b = c;
        acc++;
      end
      step();
      c++;
      if (acc == 1) bus.in = b;
      if (acc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_period", t_b - t_a, 18);
    for (int i = 0; i < 16; i++) exp_q.push_back(byte_of(a, i));
    for (int i = 0; i < 16; i++) exp_q.push_back(byte_of(b, i));
    c = 0;
    while (done_n < d0 + 2 && c < 60) begin
      step();
      c++;
    end
    chk("b2b_done", done_n - d0, 2);
    blocks_ok += 2;
    step();
    chk_idle("b2b_idle");

    // Reset after the 7th byte abandons the block.
    a = {$urandom, $urandom, $urandom, $urandom};
    bus.in = a; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(byte_of(a, i));
      step();
    end
    d0 = done_n;
    rst = 1'b1;
    #1;
    chk("rst_mid_push", bus.push, 1'b0);
    step();
    rst = 1'b0;
    chk_idle("rst_mid");
    repeat (4) step();
    chk("rst_mid_nodone", done_n, d0);
    chk_idle("rst_mid_after");
    xfer({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b0);

    // New block offered while busy after the 3rd byte is ignored.
    xfer(128'hA5A4A3A2A1A0AFAEADACABAAA9A8A7A6, -1, 0, 3, 1'b0);

    // Random data with random backpressure.
    repeat (6) xfer({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b1);

    repeat (2) step();
    chk("total_bytes", got_q.size(), exp_q.size());
    chk("total_done", done_n, blocks_ok);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) chk($sformatf("byte_%0d", i), got_q[i], exp_q[i]);
    end
    chk("stream_first", got_q.size() > 0 ? got_q[0] : 8'hXX, exp_q[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
